// File: rtl/trace_serializer.sv
// Trace serializer: turns one register/memory write record into ASCII text.
// Ports: clk, reset (sync, high); in_valid/in_ready accept handshake;
//        in_kind/in_time/in_pc/in_reg/in_addr/in_data record fields;
//        char/char_valid character stream; done pulses on the final '#'.
module trace_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_kind,
    input  logic [13:0] in_time,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_reg,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic [7:0]  char,
    output logic        char_valid,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

    localparam logic [3:0] S_CARET = 4'd0;
    localparam logic [3:0] S_TIME  = 4'd1;
    localparam logic [3:0] S_AT    = 4'd2;
    localparam logic [3:0] S_PC    = 4'd3;
    localparam logic [3:0] S_COLON = 4'd4;
    localparam logic [3:0] S_SP1   = 4'd5;
    localparam logic [3:0] S_SIGIL = 4'd6;
    localparam logic [3:0] S_OPER  = 4'd7;
    localparam logic [3:0] S_SP2   = 4'd8;
    localparam logic [3:0] S_LT    = 4'd9;
    localparam logic [3:0] S_EQ    = 4'd10;
    localparam logic [3:0] S_SP3   = 4'd11;
    localparam logic [3:0] S_DATA  = 4'd12;
    localparam logic [3:0] S_HASH  = 4'd13;

    state_t      state_q, state_d;
    logic        kind_q, kind_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] op_q, op_d;
    logic [31:0] data_q, data_d;
    // {bcd[15:0], bin[13:0]} double-dabble shift register
    logic [29:0] dd_q, dd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  seg_q, seg_d;
    logic [7:0]  char_q, char_d;
    logic        cv_q, cv_d;
    logic        done_q, done_d;
    logic        rdy_q, rdy_d;

    logic [15:0] bcd;
    logic [2:0]  dt;
    logic [1:0]  tpos;
    logic [3:0]  tdig;
    logic [4:0]  rg;
    logic [1:0]  rt;
    logic [3:0]  ro;
    logic [1:0]  dr;
    logic [4:0]  hsel;
    logic [3:0]  seg_len;
    logic [7:0]  cur_char;
    logic [13:0] sat_time;

    function automatic logic [29:0] dd_step(input logic [29:0] v);
        logic [29:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (t[14+4*i +: 4] >= 4'd5) begin
                t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
            end
        end
        return {t[28:0], 1'b0};
    endfunction

    function automatic logic [7:0] dec_c(input logic [3:0] n);
        return 8'h30 + {4'h0, n};
    endfunction

    function automatic logic [7:0] hex_c(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Character selection for the current segment / position
    always_comb begin
        bcd = dd_q[29:14];
        if (bcd[15:12] != 4'd0)     dt = 3'd4;
        else if (bcd[11:8] != 4'd0) dt = 3'd3;
        else if (bcd[7:4] != 4'd0)  dt = 3'd2;
        else                        dt = 3'd1;
        tpos = 2'(dt - 3'd1 - cnt_q[2:0]);
        tdig = bcd[{tpos, 2'b00} +: 4];

        rg = op_q[4:0];
        if (rg >= 5'd30) begin
            rt = 2'd3; ro = 4'(rg - 5'd30);
        end else if (rg >= 5'd20) begin
            rt = 2'd2; ro = 4'(rg - 5'd20);
        end else if (rg >= 5'd10) begin
            rt = 2'd1; ro = 4'(rg - 5'd10);
        end else begin
            rt = 2'd0; ro = 4'(rg);
        end
        dr = (rt != 2'd0) ? 2'd2 : 2'd1;

        // hex digits go most significant first
        hsel = {~cnt_q[2:0], 2'b00};

        seg_len  = 4'd1;
        cur_char = 8'h00;
        case (seg_q)
            S_CARET: cur_char = 8'h5e;
            S_TIME: begin
                seg_len  = {1'b0, dt};
                cur_char = dec_c(tdig);
            end
            S_AT: cur_char = 8'h40;
            S_PC: begin
                seg_len  = 4'd8;
                cur_char = hex_c(pc_q[hsel +: 4]);
            end
            S_COLON: cur_char = 8'h3a;
            S_SP1:   cur_char = 8'h20;
            S_SIGIL: cur_char = kind_q ? 8'h2a : 8'h24;
            S_OPER: begin
                if (kind_q) begin
                    seg_len  = 4'd8;
                    cur_char = hex_c(op_q[hsel +: 4]);
                end else begin
                    seg_len  = {2'b00, dr};
                    cur_char = (dr == 2'd2 && cnt_q == 4'd0) ?
                               dec_c({2'b00, rt}) : dec_c(ro);
                end
            end
            S_SP2: cur_char = 8'h20;
            S_LT:  cur_char = 8'h3c;
            S_EQ:  cur_char = 8'h3d;
            S_SP3: cur_char = 8'h20;
            S_DATA: begin
                seg_len  = 4'd8;
                cur_char = hex_c(data_q[hsel +: 4]);
            end
            S_HASH:  cur_char = 8'h23;
            default: cur_char = 8'h00;
        endcase

        sat_time = (in_time > 14'd9999) ? 14'd9999 : in_time;
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        pc_d    = pc_q;
        op_d    = op_q;
        data_d  = data_q;
        dd_d    = dd_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        char_d  = 8'h00;
        cv_d    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    kind_d  = in_kind;
                    pc_d    = in_pc;
                    op_d    = in_kind ? in_addr : {27'd0, in_reg};
                    data_d  = in_data;
                    dd_d    = {16'd0, sat_time};
                    cnt_d   = 4'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                dd_d = dd_step(dd_q);
                if (cnt_q == 4'd13) begin
                    cnt_d   = 4'd0;
                    seg_d   = S_CARET;
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            EMIT: begin
                // '#' was on the outputs this cycle: wrap up
                if (done_q) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    seg_d   = S_CARET;
                end else begin
                    char_d = cur_char;
                    cv_d   = 1'b1;
                    done_d = (seg_q == S_HASH);
                    if (cnt_q == seg_len - 4'd1) begin
                        cnt_d = 4'd0;
                        seg_d = seg_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            kind_q  <= 1'b0;
            pc_q    <= 32'd0;
            op_q    <= 32'd0;
            data_q  <= 32'd0;
            dd_q    <= 30'd0;
            cnt_q   <= 4'd0;
            seg_q   <= S_CARET;
            char_q  <= 8'h00;
            cv_q    <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            data_q  <= data_d;
            dd_q    <= dd_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            char_q  <= char_d;
            cv_q    <= cv_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready   = rdy_q;
    assign char       = char_q;
    assign char_valid = cv_q;
    assign done       = done_q;

endmodule

// File: doc/trace_serializer.md
TRACE_SERIALIZER -- requirements
Module: trace_serializer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: a trace record is presented.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a record.
REQ-005 SHALL have port in_kind, input, 1 bit: record type; 0 = register write, 1 = memory write.
REQ-006 SHALL have port in_time, input, 14 bits: time stamp, unsigned.
REQ-007 SHALL have port in_pc, input, 32 bits: instruction address.
REQ-008 SHALL have port in_reg, input, 5 bits: register number; used only when in_kind=0.
REQ-009 SHALL have port in_addr, input, 32 bits: memory address; used only when in_kind=1.
REQ-010 SHALL have port in_data, input, 32 bits: written value.
REQ-011 SHALL have port char, output, 8 bits: ASCII character stream that feeds the format checker.
REQ-012 SHALL have port char_valid, output, 1 bit: char carries a record character this cycle.
REQ-013 SHALL have port done, output, 1 bit: single-cycle pulse coincident with the final '#'.

Function
REQ-014 SHALL accept a record on a rising edge where in_valid=1 and in_ready=1, and SHALL latch all in_* fields at that edge.
REQ-015 SHALL drive in_ready=1 only in the IDLE state.
REQ-016 SHALL use the FSM states IDLE -> CONV -> EMIT -> IDLE.
REQ-017 SHALL convert the time stamp to BCD in CONV, lasting exactly 14 cycles (double-dabble, one bit per cycle).
REQ-018 SHALL saturate a latched in_time greater than 9999 to 9999 before conversion.
REQ-019 SHALL drive the first character '^' with char_valid=1 in the cycle after CONV ends, i.e. 15 cycles after the accept edge, and emit one character per cycle with no gaps.
REQ-020 SHALL emit a register record (in_kind=0) as: '^', time, '@', pc, ':', ' ', '$', reg, ' ', '<', '=', ' ', data, '#'.
REQ-021 SHALL emit a memory record (in_kind=1) as: '^', time, '@', pc, ':', ' ', '*', addr, ' ', '<', '=', ' ', data, '#'.
REQ-022 SHALL emit time and reg in decimal without leading zeros, using 1-4 digits for time and 1-2 digits for reg; a value of 0 emits "0".
REQ-023 SHALL emit pc, addr and data as exactly 8 lowercase hex digits each, most significant first, zero-padded.
REQ-024 SHALL produce a register record of 26+Dt+Dr characters and a memory record of 34+Dt characters, where Dt and Dr are the decimal digit counts.
REQ-025 SHALL assert done for exactly the '#' cycle, then return to IDLE so that in_ready=1 on the next cycle.
REQ-026 SHALL therefore allow at most one record in flight; back-to-back records are separated by at least 15 non-valid cycles.
REQ-027 SHALL drive char=8'h00 and char_valid=0 whenever not in EMIT.
REQ-028 SHALL register every output; none may depend combinationally on any in_* input.
REQ-029 SHALL ignore in_* values while in CONV or EMIT.

Reset
REQ-030 SHALL, while reset=1 at a clock edge, force state=IDLE, char=8'h00, char_valid=0, done=0, and clear all latched fields and counters.
REQ-031 SHALL drive in_ready=1 in the cycle after reset deasserts.
REQ-032 SHALL abort any record in progress when reset is asserted during CONV or EMIT, with no further characters and no done pulse.
REQ-033 SHALL ignore a record presented with in_valid=1 while reset=1.

Verification
REQ-034 SHALL cover a register record: kind=0, time=5, pc=0x00003000, reg=3, data=0x12 -> "^5@00003000: $3 <= 00000012#", 28 chars, first char 15 cycles after accept, done on '#'.
REQ-035 SHALL cover a memory record: kind=1, time=1234, pc=0xdeadbeef, addr=0x0000abcd, data=0xffffffff -> "^1234@deadbeef: *0000abcd <= ffffffff#", 38 chars.
REQ-036 SHALL cover boundary values: time=0 with reg=0 -> "^0@...: $0 <= ...#"; time=16383 -> time field "9999"; reg=31 -> "31".
REQ-037 SHALL cover back-to-back records: in_valid held high -> second accept on the cycle after done, in_ready low throughout CONV/EMIT, in_* changes during EMIT have no effect on the output.
REQ-038 SHALL cover reset mid-operation: reset asserted on the 10th EMIT char -> next cycle char_valid=0, char=0, done never pulses, in_ready=1 after release.
REQ-039 SHALL cover loop-back: output char feeds the format checker -> its format_type=1 for register records and 2 for memory records, on the cycle after '#'.
